// File: rtl/logs_popcount_acc_if.sv
// Word-in / result-out handshake bundle for the multi-word popcount accumulator.
// Valid/ready: a transfer happens on a rising edge where valid && ready; the sender holds its payload stable while valid && !ready.
interface logs_popcount_acc_if #(
  parameter int NBITS = 16,
  parameter int CW    = 8
);
  logic [NBITS-1:0] in_word;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    thresh;
  logic [CW-1:0]    out_count;
  logic             out_ge;
  logic             out_overflow;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_word, in_last, in_valid, thresh, out_ready,
    input  in_ready, out_count, out_ge, out_overflow, out_valid
  );

  modport slave (
    input  in_word, in_last, in_valid, thresh, out_ready,
    output in_ready, out_count, out_ge, out_overflow, out_valid
  );
endinterface

// File: rtl/logs_popcount_acc.sv
// Sequential popcount over a frame of NBITS-wide words, CHUNK bits per cycle,
// with a registered total, threshold compare and overflow flag per frame.
module logs_popcount_acc #(
  parameter int NBITS    = 16,
  parameter int CHUNK    = 4,
  parameter int MAXWORDS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  logs_popcount_acc_if.slave   bus,
  output logic [1:0]           state_dbg
);
  localparam int CW  = $clog2(NBITS*MAXWORDS+1);
  localparam int NCH = NBITS / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = $clog2(CHUNK+1);
  localparam int WW  = $clog2(MAXWORDS+2);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] word_q;
  logic             last_q;
  logic [CW-1:0]    thr_q;
  logic [CW-1:0]    acc;
  logic [WW-1:0]    wcnt;
  logic             ovf;
  logic [IW-1:0]    idx;
  logic [PW-1:0]    pc;
  logic [CW-1:0]    acc_nx;
  logic             skip;
  logic             last_add;

  // The word register shifts right each scan cycle, so the current chunk is always the low bits.
  always_comb begin
    pc = '0;
    for (int i = 0; i < CHUNK; i++) pc = pc + PW'(word_q[i]);
  end

  // Words beyond MAXWORDS still take their scan cycles but contribute nothing.
  assign skip     = (wcnt >= WW'(MAXWORDS));
  assign acc_nx   = skip ? acc : acc + CW'(pc);
  assign last_add = (idx == IW'(NCH-1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = SCAN;
      SCAN:    if (last_add) state_d = last_q ? DONE : IDLE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign state_dbg     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      word_q           <= '0;
      last_q           <= 1'b0;
      thr_q            <= '0;
      acc              <= '0;
      wcnt             <= '0;
      ovf              <= 1'b0;
      idx              <= '0;
      bus.out_count    <= '0;
      bus.out_ge       <= 1'b0;
      bus.out_overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            word_q <= bus.in_word;
            last_q <= bus.in_last;
            idx    <= '0;
            if (wcnt == '0) thr_q <= bus.thresh;
            if (skip) ovf <= 1'b1;
          end
        end
        SCAN: begin
          acc    <= acc_nx;
          word_q <= word_q >> CHUNK;
          idx    <= idx + IW'(1);
          if (last_add) begin
            idx <= '0;
            if (wcnt <= WW'(MAXWORDS)) wcnt <= wcnt + WW'(1);
            if (last_q) begin
              bus.out_count    <= acc_nx;
              bus.out_ge       <= (acc_nx >= thr_q);
              bus.out_overflow <= ovf;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            acc  <= '0;
            wcnt <= '0;
            ovf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_logs_popcount_acc.sv
// Directed bench for logs_popcount_acc at NBITS=16, CHUNK=4, MAXWORDS=8 (CW=8);
// expected totals are hand-computed popcounts of the driven words.
module tb_logs_popcount_acc;
  localparam int NBITS = 16;
  localparam int CW    = 8;
  localparam int NCH   = 4;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;

  logs_popcount_acc_if #(.NBITS(NBITS), .CW(CW)) bus ();

  logs_popcount_acc #(.NBITS(16), .CHUNK(4), .MAXWORDS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one word, then checks in_ready stays low for NCH cycles and the
  // post-scan state; returns at the negedge NCH cycles after acceptance.
  task automatic send_word(input logic [15:0] w, input logic l, input logic [7:0] t);
    int n;
    n = 0;
    bus.in_word  = w;
    bus.in_last  = l;
    bus.thresh   = t;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      check("scan_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("scan_out_valid", {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk);
    end
    check("post_out_valid", {31'd0, bus.out_valid}, {31'd0, l});
    check("post_in_ready", {31'd0, bus.in_ready}, {31'd0, !l});
  endtask

  task automatic get_result(input logic [7:0] c, input logic ge, input logic ov, input int hold);
    check("res_valid", {31'd0, bus.out_valid}, 32'd1);
    check("res_count", {24'd0, bus.out_count}, {24'd0, c});
    check("res_ge", {31'd0, bus.out_ge}, {31'd0, ge});
    check("res_ovf", {31'd0, bus.out_overflow}, {31'd0, ov});
    if (hold > 0) begin
      bus.in_word  = 16'hFFFF;
      bus.in_last  = 1'b1;
      bus.in_valid = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check("hold_count", {24'd0, bus.out_count}, {24'd0, c});
        check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("taken_valid", {31'd0, bus.out_valid}, 32'd0);
    check("taken_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_word   = '0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.thresh    = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_count", {24'd0, bus.out_count}, 32'd0);
    check("rst_ge", {31'd0, bus.out_ge}, 32'd0);
    check("rst_ovf", {31'd0, bus.out_overflow}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Single full word
    send_word(16'hFFFF, 1'b1, 8'd16);
    get_result(8'd16, 1'b1, 1'b0, 0);

    // Three-word frame: 1 + 8 + 8 = 17 < 18
    send_word(16'h0001, 1'b0, 8'd18);
    send_word(16'h00FF, 1'b0, 8'd18);
    send_word(16'hF0F0, 1'b1, 8'd18);
    get_result(8'd17, 1'b0, 1'b0, 0);

    // Backpressure with a competing word offered; the next frame must be unaffected
    send_word(16'h0F0F, 1'b1, 8'd0);
    get_result(8'd8, 1'b1, 1'b0, 5);
    send_word(16'h0001, 1'b1, 8'd1);
    get_result(8'd1, 1'b1, 1'b0, 0);

    // Overflow: ninth word ignored, sticky flag reported then cleared
    for (int i = 0; i < 9; i++) send_word(16'hFFFF, (i == 8), 8'd0);
    get_result(8'd128, 1'b1, 1'b1, 0);
    send_word(16'h0003, 1'b1, 8'd3);
    get_result(8'd2, 1'b0, 1'b0, 0);

    // Reset after two scan cycles discards the frame
    bus.in_word  = 16'hFFFF;
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst_count", {24'd0, bus.out_count}, 32'd0);
    check("mrst_ge", {31'd0, bus.out_ge}, 32'd0);
    check("mrst_ovf", {31'd0, bus.out_overflow}, 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("mrst_no_result", seen, 32'd0);
    check("mrst_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    send_word(16'h8001, 1'b1, 8'd0);
    get_result(8'd2, 1'b1, 1'b0, 0);

    // Threshold boundaries
    send_word(16'h00FF, 1'b1, 8'd8);
    get_result(8'd8, 1'b1, 1'b0, 0);
    send_word(16'h00FF, 1'b1, 8'd9);
    get_result(8'd8, 1'b0, 1'b0, 0);
    send_word(16'h0000, 1'b1, 8'd0);
    get_result(8'd0, 1'b1, 1'b0, 0);

    // Threshold lowered on the second word must not be used: 12 < 20
    send_word(16'h00FF, 1'b0, 8'd20);
    send_word(16'h000F, 1'b1, 8'd0);
    get_result(8'd12, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
